// File: rtl/sar_result_tx.sv
// sar_result_tx: buffers SAR conversion codes and sends each one as a UART-style frame
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   eoc_i          end-of-conversion; its rising edge captures code_in_i
//   code_in_i      10-bit conversion result
//   clr_ovf_i      synchronous clear of overflow_o and drop_cnt_o
//   tx_out_o       registered serial line, idle high: start, D9..D0, even parity, stop
//   busy_o         high while a frame is in progress
//   fifo_level_o   number of buffered codes
//   overflow_o     sticky flag, set when a code is dropped
//   drop_cnt_o     saturating count of dropped codes
module sar_result_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        eoc_i,
    input  logic [9:0]                  code_in_i,
    input  logic                        clr_ovf_i,
    output logic                        tx_out_o,
    output logic                        busy_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
    output logic                        overflow_o,
    output logic [7:0]                  drop_cnt_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [2:0]    state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic [9:0]    sh_q, sh_d, head;
    logic          par_q, par_d, tx_q, tx_d, eoc_q, ovf_q, ovf_d;
    logic [7:0]    drop_q, drop_d, drop_base;
    logic          push, pop, full, last, accept, drop;

    always_comb begin
        push      = eoc_i & ~eoc_q;
        full      = cnt_q == LW'(FIFO_DEPTH);
        last      = baud_q == BW'(CLKS_PER_BIT - 1);
        head      = mem[rd_ptr_q];
        // The pop is decided on the pre-push level, so a full FIFO that pops
        // in the same cycle still has room for the incoming code.
        pop       = (cnt_q != '0) && (state_q == IDLE || (state_q == STOP && last));
        accept    = push & (~full | pop);
        drop      = push & full & ~pop;
        cnt_d     = cnt_q + LW'(accept) - LW'(pop);
        // Clear acts before a same-cycle drop is counted.
        ovf_d     = drop | (ovf_q & ~clr_ovf_i);
        drop_base = clr_ovf_i ? 8'd0 : drop_q;
        drop_d    = (drop && drop_base != 8'hFF) ? drop_base + 8'd1 : drop_base;
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BW'(1);
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        if (pop) begin
            state_d = START;
            baud_d  = '0;
            sh_d    = head;
            par_d   = ^head;
        end else begin
            case (state_q)
                IDLE: baud_d = '0;
                START: if (last) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = 4'd0;
                end
                DATA: if (last) begin
                    baud_d  = '0;
                    state_d = (bit_q == 4'd9) ? PARITY : DATA;
                    bit_d   = bit_q + 4'd1;
                    sh_d    = {sh_q[8:0], 1'b0};
                end
                PARITY: if (last) begin
                    state_d = STOP;
                    baud_d  = '0;
                end
                STOP: if (last) begin
                    state_d = IDLE;
                    baud_d  = '0;
                end
                default: begin
                    state_d = IDLE;
                    baud_d  = '0;
                end
            endcase
        end
        // Line level follows the next state so tx_out_o can be a plain flop.
        tx_d = (state_d == START)  ? 1'b0 :
               (state_d == DATA)   ? sh_d[9] :
               (state_d == PARITY) ? par_d : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            eoc_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            eoc_q    <= eoc_i;
            wr_ptr_q <= accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_q <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr_q] <= code_in_i;
    end

    assign tx_out_o     = tx_q;
    assign busy_o       = state_q != IDLE;
    assign fifo_level_o = cnt_q;
    assign overflow_o   = ovf_q;
    assign drop_cnt_o   = drop_q;
endmodule

// File: tb/tb_sar_result_tx.sv
// tb_sar_result_tx: self-checking bench for sar_result_tx against a queue-based frame model
module tb_sar_result_tx;
    localparam int C  = 4;
    localparam int D  = 4;
    localparam int FL = 13 * C;

    logic       clk, rst_n, eoc, clr;
    logic [9:0] code;
    logic       tx, busy, ovf;
    logic [2:0] level;
    logic [7:0] drop;

    sar_result_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .eoc_i(eoc), .code_in_i(code), .clr_ovf_i(clr),
        .tx_out_o(tx), .busy_o(busy), .fifo_level_o(level), .overflow_o(ovf), .drop_cnt_o(drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [9:0] code;
        logic       par;
    } vec_t;
    vec_t vt[6];

    int errs = 0;
    int checks = 0;

    logic [9:0] mq[$];
    int         rem;
    logic [9:0] cur;
    logic       m_ovf, m_eoc;
    int         m_drop;

    logic       rx_act;
    int         rx_t;
    logic [12:0] rb;
    logic [9:0] rx_q[$];
    logic       rx_pq[$];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic fbit(input logic [9:0] c, input int i);
        int ones;
        if (i == 0) return 1'b0;
        if (i <= 10) return ((32'(c) >> (10 - i)) & 1) == 1;
        if (i == 11) begin
            ones = 0;
            for (int k = 0; k < 10; k++) ones += (32'(c) >> k) & 1;
            return (ones % 2) == 1;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        mq.delete();
        rem    = 0;
        cur    = '0;
        m_ovf  = 1'b0;
        m_eoc  = 1'b0;
        m_drop = 0;
        rx_act = 1'b0;
        rx_t   = 0;
    endtask

    task automatic model_edge();
        bit pu, po, fu;
        if (!rst_n) begin
            model_reset();
        end else begin
            pu    = eoc && !m_eoc;
            m_eoc = eoc;
            po    = mq.size() != 0 && rem <= 1;
            fu    = mq.size() == D;
            if (clr) begin
                m_ovf  = 1'b0;
                m_drop = 0;
            end
            if (po) begin
                cur = mq.pop_front();
                rem = FL;
            end else if (rem > 0) begin
                rem--;
            end
            if (pu) begin
                if (!fu || po) mq.push_back(code);
                else begin
                    m_ovf = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end
        end
    endtask

    task automatic step();
        logic [9:0] rc;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("tx_out", 32'(tx), 32'(rem > 0 ? fbit(cur, (FL - rem) / C) : 1'b1));
        chk("busy", 32'(busy), 32'(rem > 0));
        chk("fifo_level", 32'(level), 32'(mq.size()));
        chk("overflow", 32'(ovf), 32'(m_ovf));
        chk("drop_cnt", 32'(drop), 32'(m_drop));
        if (rst_n) begin
            if (!rx_act && tx === 1'b0) begin
                rx_act = 1'b1;
                rx_t   = 0;
            end
            if (rx_act) begin
                if (rx_t % C == C / 2) rb[rx_t / C] = tx;
                rx_t++;
                if (rx_t == FL) begin
                    rx_act = 1'b0;
                    for (int k = 0; k < 10; k++) rc[9 - k] = rb[1 + k];
                    rx_q.push_back(rc);
                    rx_pq.push_back(rb[11]);
                end
            end
        end
    endtask

    task automatic pulse(input logic [9:0] c, input int gap);
        eoc  = 1'b1;
        code = c;
        step();
        eoc = 1'b0;
        repeat (gap - 1) step();
    endtask

    initial begin
        vt[0] = '{10'h2A5, 1'b1};
        vt[1] = '{10'h000, 1'b0};
        vt[2] = '{10'h3FF, 1'b0};
        vt[3] = '{10'h001, 1'b1};
        vt[4] = '{10'h200, 1'b1};
        vt[5] = '{10'h0F0, 1'b0};

        rst_n = 1'b0;
        eoc   = 1'b0;
        clr   = 1'b0;
        code  = '0;
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);

        foreach (vt[i]) begin
            rx_q.delete();
            rx_pq.delete();
            eoc  = 1'b1;
            code = vt[i].code;
            step();
            eoc = 1'b0;
            chk("lat_pre", 32'(tx), 32'd1);
            step();
            chk("lat_start", 32'(tx), 32'd0);
            chk("lat_busy", 32'(busy), 32'd1);
            repeat (FL) step();
            chk("frame_end_busy", 32'(busy), 32'd0);
            chk("frame_count", 32'(rx_q.size()), 32'd1);
            chk("frame_code", 32'(rx_q.size() > 0 ? rx_q[0] : 10'h3FF ^ vt[i].code), 32'(vt[i].code));
            chk("frame_parity", 32'(rx_pq.size() > 0 ? rx_pq[0] : ~vt[i].par), 32'(vt[i].par));
        end

        rx_q.delete();
        eoc  = 1'b1;
        code = 10'h155;
        repeat (30) step();
        eoc = 1'b0;
        repeat (2 * FL) step();
        chk("long_eoc_frames", 32'(rx_q.size()), 32'd1);
        chk("long_eoc_code", 32'(rx_q.size() > 0 ? rx_q[0] : 10'h0), 32'h155);

        rx_q.delete();
        for (int i = 1; i <= 6; i++) pulse(10'(i), 8);
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_drop1", 32'(drop), 32'd1);
        repeat (5 * FL) step();
        chk("ovf_frames", 32'(rx_q.size()), 32'd5);
        for (int k = 0; k < 5; k++)
            chk("ovf_code", 32'(rx_q.size() > k ? rx_q[k] : 10'h0), 32'(k + 1));
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_ovf", 32'(ovf), 32'd0);
        chk("clr_drop", 32'(drop), 32'd0);

        for (int i = 0; i < 6; i++) pulse(10'h100 + 10'(i), 2);
        chk("pre_clr_drop", 32'(drop), 32'd1);
        clr = 1'b1;
        pulse(10'h1FF, 1);
        clr = 1'b0;
        chk("clr_push_ovf", 32'(ovf), 32'd1);
        chk("clr_push_drop", 32'(drop), 32'd1);
        repeat (6 * FL) step();
        clr = 1'b1;
        step();
        clr = 1'b0;

        for (int i = 0; i < 5; i++) pulse(10'h050 + 10'(i), 2);
        begin
            int n;
            n = 0;
            while (!(rem == 1 && mq.size() == D) && n < 2 * FL) begin
                step();
                n++;
            end
            chk("stop_full_found", 32'(n < 2 * FL), 32'd1);
        end
        pulse(10'h3C3, 1);
        chk("pushpop_ovf", 32'(ovf), 32'd0);
        chk("pushpop_level", 32'(level), 32'(D));
        rx_q.delete();
        repeat (6 * FL) step();
        chk("pushpop_last", 32'(rx_q.size() > 0 ? rx_q[$] : 10'h0), 32'h3C3);

        pulse(10'h2A5, 2);
        pulse(10'h111, 2);
        pulse(10'h222, 2);
        repeat (3 * C) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_level", 32'(level), 32'd0);
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
        rx_q.delete();
        repeat (100) step();
        chk("post_rst_frames", 32'(rx_q.size()), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            int dens;
            dens = (i / 500) % 3 == 0 ? 3 : (i / 500) % 3 == 1 ? 15 : 50;
            eoc  = $urandom_range(0, 99) < dens;
            code = 10'($urandom);
            clr  = $urandom_range(0, 199) == 0;
            step();
        end
        eoc = 1'b0;
        clr = 1'b0;
        repeat (6 * FL) step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
